// File: rtl/dec_text_parser.sv
// dec_text_parser
//   Assembles runs of ASCII decimal digits into an unsigned binary value.
//   One character is taken per transfer (chr_vld & chr_rdy). Leading
//   separators are skipped. The first non-digit after a digit run ends the
//   number and is consumed. The result is then published for one cycle
//   (val_vld) in the DONE state.
//
// Ports
//   clk      system clock, rising edge
//   rst_b    asynchronous active-low reset
//   chr      ASCII character in
//   chr_vld  chr is valid this cycle
//   chr_rdy  parser accepts chr this cycle (low only in DONE)
//   val      parsed value, saturated at 2^WIDTH-1, held until next result
//   val_vld  one-cycle pulse: val/ovf/ndig are new
//   ovf      value exceeded 2^WIDTH-1
//   ndig     digit count of the number, saturating at 15
//   busy     a number is being accumulated
module dec_text_parser #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [7:0]       chr,
  input  logic             chr_vld,
  output logic             chr_rdy,
  output logic [WIDTH-1:0] val,
  output logic             val_vld,
  output logic             ovf,
  output logic [3:0]       ndig,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAXV = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [3:0]       cnt;
  logic             ovfl;

  logic             is_dig;
  logic [3:0]       d;
  logic             xfer;

  logic [WIDTH+3:0] acc_ext;
  logic [WIDTH+3:0] prod;
  logic             prod_ovf;
  logic [WIDTH-1:0] acc_nxt;
  logic [3:0]       cnt_nxt;

  // Character-to-nibble map: 0x30..0x39 -> 0..9, everything else -> 15.
  always_comb begin
    is_dig = (chr >= 8'h30) && (chr <= 8'h39);
    d      = is_dig ? chr[3:0] : 4'hF;
  end

  assign xfer = chr_vld & chr_rdy;

  // acc*10 + d at WIDTH+4 bits: (2^W-1)*10+9 < 2^(W+4), so the top nibble
  // being non-zero is an exact overflow test. Shift-add avoids a multiplier.
  always_comb begin
    acc_ext  = {4'd0, acc};
    prod     = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, d};
    prod_ovf = ovfl | (|prod[WIDTH+3:WIDTH]);
    acc_nxt  = prod_ovf ? MAXV : prod[WIDTH-1:0];
    cnt_nxt  = (cnt == 4'hF) ? cnt : cnt + 4'd1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && is_dig)  state_nxt = ACC;
      ACC:     if (xfer && !is_dig) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    chr_rdy = (state != DONE);
    busy    = (state == ACC);
    val_vld = (state == DONE);
  end

  // Accumulator and result registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc  <= '0;
      cnt  <= '0;
      ovfl <= 1'b0;
      val  <= '0;
      ovf  <= 1'b0;
      ndig <= '0;
    end else if (xfer) begin
      case (state)
        IDLE: begin
          if (is_dig) begin
            acc  <= WIDTH'(d);
            cnt  <= 4'd1;
            ovfl <= 1'b0;
          end
        end
        ACC: begin
          if (is_dig) begin
            acc  <= acc_nxt;
            cnt  <= cnt_nxt;
            ovfl <= prod_ovf;
          end else begin
            // terminator: publish, DONE raises val_vld next cycle
            val  <= acc;
            ovf  <= ovfl;
            ndig <= cnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_text_parser.sv
module tb_dec_text_parser;
  localparam int W = 16;
  localparam longint MAXV = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic [7:0]   chr = 8'h00;
  logic         chr_vld = 1'b0;
  logic         chr_rdy;
  logic [W-1:0] val;
  logic         val_vld;
  logic         ovf;
  logic [3:0]   ndig;
  logic         busy;

  dec_text_parser #(.WIDTH(W)) dut (
    .clk(clk), .rst_b(rst_b), .chr(chr), .chr_vld(chr_vld), .chr_rdy(chr_rdy),
    .val(val), .val_vld(val_vld), .ovf(ovf), .ndig(ndig), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference state: digits of the number in progress, last published result
  byte unsigned dq[$];
  bit           m_done = 0;
  longint       last_val = 0;
  longint       last_ovf = 0;
  longint       last_nd = 0;
  int           npulse = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_dig(input byte unsigned c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Decimal string value, clamped to MAXV once it ever exceeds it.
  task automatic ref_parse(output longint v, output longint o, output longint n);
    v = 0; o = 0;
    foreach (dq[i]) begin
      v = v * 10 + longint'(dq[i] - 8'h30);
      if (v > MAXV) begin o = 1; v = MAXV; end
    end
    n = (dq.size() > 15) ? 15 : dq.size();
  endtask

  // One cycle: drive at negedge, clock, observe at next negedge.
  task automatic step(input logic [7:0] c, input bit v, output bit took);
    longint ev, eo, en;
    chr = c; chr_vld = v;
    #1;
    chk("chr_rdy", {63'd0, chr_rdy}, {63'd0, !m_done});
    took = v && !m_done;
    @(posedge clk);
    @(negedge clk);
    m_done = 0;
    if (took) begin
      if (is_dig(c)) dq.push_back(c);
      else if (dq.size() > 0) begin
        ref_parse(ev, eo, en);
        last_val = ev; last_ovf = eo; last_nd = en;
        dq.delete();
        m_done = 1;
        npulse++;
      end
    end
    chk("val_vld", {63'd0, val_vld}, {63'd0, m_done});
    chk("val", 64'(val), last_val);
    chk("ovf", 64'(ovf), last_ovf);
    chk("ndig", 64'(ndig), last_nd);
    chk("busy", {63'd0, busy}, {63'd0, dq.size() > 0});
  endtask

  task automatic send(input logic [7:0] c);
    bit t;
    int n = 0;
    do begin
      step(c, 1'b1, t);
      n++;
    end while (!t && n < 4);
    if (!t) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    bit t;
    repeat (n) step(8'($urandom_range(0, 255)), 1'b0, t);
  endtask

  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (maxgap > 0) idle($urandom_range(1, maxgap));
    end
  endtask

  function automatic logic [7:0] rand_sep();
    logic [7:0] c;
    do c = 8'($urandom_range(0, 255)); while (is_dig(c));
    return c;
  endfunction

  initial begin
    int p0;
    // reset state
    @(negedge clk);
    chk("rst_val", 64'(val), 64'd0);
    chk("rst_vld", {63'd0, val_vld}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_ndig", 64'(ndig), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rdy", {63'd0, chr_rdy}, 64'd1);
    @(negedge clk);
    rst_b = 1'b1;

    // back-to-back "123\r"
    send_str("123", 0); send(8'h0D);
    // gapped "  7,"
    p0 = npulse;
    send_str("  7,", 3);
    chk("one_pulse_7", 64'(npulse - p0), 64'd1);
    // saturation boundaries
    send_str("65535 ", 0);
    send_str("65536 ", 0);
    send_str("9999999 ", 0);
    // leading zeros, then a char held through DONE
    send_str("0000042\n", 0);
    send_str("8\n", 0);
    // digit count saturation
    send_str("000000000000000000005 ", 0);

    // async reset mid-number
    send_str("45", 0);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_val", 64'(val), 64'd0);
    chk("arst_vld", {63'd0, val_vld}, 64'd0);
    chk("arst_ovf", {63'd0, ovf}, 64'd0);
    chk("arst_ndig", 64'(ndig), 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_rdy", {63'd0, chr_rdy}, 64'd1);
    @(negedge clk);
    rst_b = 1'b1;
    dq.delete(); m_done = 0; last_val = 0; last_ovf = 0; last_nd = 0;
    send_str("6", 0); send(8'h0D);

    // full byte sweep, each followed by CR
    p0 = npulse;
    for (int b = 0; b < 256; b++) begin
      send(8'(b));
      send(8'h0D);
    end
    chk("sweep_pulses", 64'(npulse - p0), 64'd10);

    // random numbers with random separators and gaps
    for (int k = 0; k < 60; k++) begin
      int nsep = $urandom_range(0, 2);
      int ndg = $urandom_range(1, 9);
      for (int i = 0; i < nsep; i++) begin
        send(rand_sep());
        idle($urandom_range(0, 1));
      end
      for (int i = 0; i < ndg; i++) begin
        send(8'h30 + 8'($urandom_range(0, 9)));
        idle($urandom_range(0, 1));
      end
      send(rand_sep());
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
